// File: rtl/collatz_sweep.sv
// collatz_sweep: sweeps RAM_WORDS consecutive Collatz start values through one iterator and stores each sequence length.
// Optional max tracking (max_count/max_start) is enabled with COLLATZ_SWEEP_MAX_TRACK_EN.
module collatz_sweep #(
    parameter int RAM_WORDS = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int COUNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [31:0]              start,
    input  logic [RAM_ADDR_BITS-1:0] rd_addr,
    output logic [COUNT_BITS-1:0]    count,
    output logic                     busy,
`ifdef COLLATZ_SWEEP_MAX_TRACK_EN
    output logic [COUNT_BITS-1:0]    max_count,
    output logic [31:0]              max_start,
`endif
    output logic                     done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, FIN} state_t;

    state_t                   state, state_next;
    logic [31:0]              start_q, value, load_value;
    logic [RAM_ADDR_BITS-1:0] index;
    logic [COUNT_BITS-1:0]    steps;
    logic [COUNT_BITS-1:0]    ram [RAM_WORDS];
    logic                     last;

    assign load_value = start_q + 32'(index);
    assign last = &index;
    assign busy = state inside {LOAD, RUN, WRITE};

    // go takes priority over every state, including an in-flight sweep
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = load_value == 32'd0 ? WRITE : RUN;
            RUN:     state_next = value == 32'd1 ? WRITE : RUN;
            WRITE:   state_next = last ? FIN : LOAD;
            FIN:     state_next = IDLE;
            default: state_next = state;
        endcase
        if (go)
            state_next = LOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= '0;
            value   <= '0;
            index   <= '0;
            steps   <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            if (go) begin
                start_q <= start;
                index   <= '0;
                done    <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        value <= load_value;
                        steps <= load_value == 32'd0 ? '0 : COUNT_BITS'(1);
                    end
                    RUN: if (value != 32'd1) begin
                        value <= value[0] ? value * 32'd3 + 32'd1 : value >> 1;
                        steps <= &steps ? steps : steps + COUNT_BITS'(1);
                    end
                    WRITE: begin
                        index <= index + RAM_ADDR_BITS'(1);
                        done  <= last;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk)
        if (state == WRITE)
            ram[index] <= steps;

    // read-before-write: a same-cycle write to rd_addr shows up one cycle later
    always_ff @(posedge clk)
        count <= reset ? '0 : ram[rd_addr];

`ifdef COLLATZ_SWEEP_MAX_TRACK_EN
    always_ff @(posedge clk) begin
        if (reset || go) begin
            max_count <= '0;
            max_start <= '0;
        end else if (state == WRITE && steps > max_count) begin
            max_count <= steps;
            max_start <= load_value;
        end
    end
`endif
endmodule
